// File: rtl/alu_control_seq_if.sv
// alu_control_seq_if: handshake/bus bundle between the ID/EX stage, the ALU
// control sequencer and its consumers (ALU, HI/LO mult/div unit, hazard unit).
//   master : upstream driver (in_valid, aluop, funct, ex_stall); samples outputs
//   slave  : alu_control_seq itself
// Signals:
//   in_valid, aluop[1:0], funct[5:0], ex_stall      -> sequencer
//   out_valid, select[SEL_W-1:0], md_start, md_op,  <- sequencer
//   md_busy, stall_req, hilo_we, illegal_op
interface alu_control_seq_if #(
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic             ex_stall;
  logic             out_valid;
  logic [SEL_W-1:0] select;
  logic             md_start;
  logic [1:0]       md_op;
  logic             md_busy;
  logic             stall_req;
  logic             hilo_we;
  logic             illegal_op;

  modport master (
    output in_valid, aluop, funct, ex_stall,
    input  out_valid, select, md_start, md_op, md_busy, stall_req, hilo_we,
           illegal_op
  );

  modport slave (
    input  in_valid, aluop, funct, ex_stall,
    output out_valid, select, md_start, md_op, md_busy, stall_req, hilo_we,
           illegal_op
  );
endinterface

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered EX-stage ALU control decoder with a multi-cycle
// MULT/DIV sequencer.
//   clk       : single clock, posedge
//   rst       : synchronous active-high reset
//   bus       : alu_control_seq_if.slave (decode request in, select / mult-div
//               control / stall out)
// Decode has one cycle of registered latency. MULT/MULTU/DIV/DIVU launch a
// down-counter FSM IDLE -> MUL|DIV -> DONE -> IDLE; md_busy/stall_req are
// decoded from the registered state, hilo_we pulses as DONE retires.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN
//   defined   : unlisted R-type functs raise a one-cycle illegal_op pulse
//   undefined : unlisted R-type functs decode to ADD, illegal_op tied 0
module alu_control_seq #(
  parameter int SEL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_control_seq_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef struct packed {
    logic       md;       // mult/div funct
    logic       illegal;  // R-type funct outside both lists
    logic [1:0] md_op;    // {signed_n, div}
    logic [3:0] code;
  } dec_t;

  state_t           state;
  logic [7:0]       cnt;
  logic             out_valid_q;
  logic [SEL_W-1:0] select_q;
  logic             md_start_q;
  logic [1:0]       md_op_q;
  logic             hilo_we_q;
  dec_t             dec;

  // funct[0] is the unsigned bit and funct[1] the divide bit for 0110xx
  always_comb begin
    dec         = '0;
    dec.code    = OP_ADD;
    dec.md_op   = {bus.funct[0], bus.funct[1]};
    case (bus.aluop)
      2'b00: dec.code = OP_ADD;
      2'b01: dec.code = OP_SUB;
      2'b11: dec.code = OP_OR;
      default: begin
        case (bus.funct)
          6'b100000, 6'b100001: dec.code = OP_ADD;
          6'b100010, 6'b100011: dec.code = OP_SUB;
          6'b100100:            dec.code = OP_AND;
          6'b100101:            dec.code = OP_OR;
          6'b100110:            dec.code = OP_XOR;
          6'b100111:            dec.code = OP_NOR;
          6'b101010:            dec.code = OP_SLT;
          6'b101011:            dec.code = OP_SLTU;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: dec.md   = 1'b1;
          default:              dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec.illegal;
`endif

  // Pulses (md_start, hilo_we, illegal_op) self-clear every cycle; the rest
  // of the state only moves when ex_stall is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      select_q    <= '0;
      md_start_q  <= 1'b0;
      md_op_q     <= 2'b00;
      hilo_we_q   <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      md_start_q <= 1'b0;
      hilo_we_q  <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
      if (!bus.ex_stall) begin
        case (state)
          IDLE: begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              if (dec.md) begin
                md_start_q <= 1'b1;
                md_op_q    <= dec.md_op;
                state      <= dec.md_op[0] ? DIV : MUL;
                cnt        <= dec.md_op[0] ? DIV_LOAD : MUL_LOAD;
              end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
              else if (dec.illegal) begin
                illegal_q <= 1'b1;
              end
`endif
              else begin
                out_valid_q <= 1'b1;
                select_q    <= SEL_W'(dec.code);
              end
            end
          end
          MUL, DIV: begin
            if (cnt == 8'd0) state <= DONE;
            else             cnt   <= cnt - 8'd1;
          end
          DONE: begin
            hilo_we_q <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.select     = select_q;
  assign bus.md_start   = md_start_q;
  assign bus.md_op      = md_op_q;
  assign bus.md_busy    = (state != IDLE);
  assign bus.stall_req  = (state != IDLE);
  assign bus.hilo_we    = hilo_we_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq (MUL_CYCLES=4, DIV_CYCLES=32).
module tb_alu_control_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_control_seq_if #(.SEL_W(4)) bus ();

  alu_control_seq #(.SEL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    bus.in_valid = v;
    bus.aluop    = op;
    bus.funct    = fn;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b10, 6'b011010);
    bus.ex_stall = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++;
    if (bus.select !== 4'b0000) begin errors++; $display("FAIL reset_select got %b exp 0000", bus.select); end
    checks++;
    if ({bus.md_start, bus.md_op, bus.md_busy, bus.stall_req, bus.hilo_we, bus.illegal_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset_md got %b exp 0000000",
               {bus.md_start, bus.md_op, bus.md_busy, bus.stall_req, bus.hilo_we, bus.illegal_op});
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 6'b0);
    step();
  endtask

  task automatic test_rtype();
    logic [5:0] fn [10];
    logic [3:0] ex [10];
    fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
           6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
    ex = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
           4'b0001, 4'b0011, 4'b0100, 4'b0111, 4'b1000};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b10, fn[i]);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.select !== ex[i]) begin
        errors++;
        $display("FAIL rtype_%b got v=%b sel=%b exp v=1 sel=%b", fn[i], bus.out_valid, bus.select, ex[i]);
      end
    end
    drive(1'b0, 2'b10, 6'b100000);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.select !== 4'b1000) begin
      errors++;
      $display("FAIL idle_hold got v=%b sel=%b exp v=0 sel=1000", bus.out_valid, bus.select);
    end
  endtask

  task automatic test_aluop();
    logic [1:0] op [3];
    logic [3:0] ex [3];
    logic [5:0] fn [3];
    op = '{2'b00, 2'b01, 2'b11};
    ex = '{4'b0010, 4'b0110, 4'b0001};
    fn = '{6'b011000, 6'b111111, 6'b100100};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, op[i], fn[i]);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.select !== ex[i] || bus.md_busy !== 1'b0) begin
        errors++;
        $display("FAIL aluop_%b got v=%b sel=%b busy=%b exp v=1 sel=%b busy=0",
                 op[i], bus.out_valid, bus.select, bus.md_busy, ex[i]);
      end
    end
    // ex_stall freezes out_valid/select even with a new valid input
    drive(1'b1, 2'b00, 6'b0);
    bus.ex_stall = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.select !== 4'b0001) begin
      errors++;
      $display("FAIL stall_hold got v=%b sel=%b exp v=1 sel=0001", bus.out_valid, bus.select);
    end
    bus.ex_stall = 1'b0;
    drive(1'b0, 2'b00, 6'b0);
    step();
  endtask

  task automatic test_mult_back_to_back();
    drive(1'b1, 2'b10, 6'b011000);
    step();
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 2'b00 || bus.stall_req !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mult_start got st=%b op=%b sr=%b v=%b exp 1 00 1 0",
               bus.md_start, bus.md_op, bus.stall_req, bus.out_valid);
    end
    drive(1'b0, 2'b00, 6'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (bus.hilo_we !== (k == 5) || bus.stall_req !== (k < 5) || bus.md_start !== 1'b0) begin
        errors++;
        $display("FAIL mult_cyc%0d got we=%b sr=%b st=%b exp we=%b sr=%b st=0",
                 k, bus.hilo_we, bus.stall_req, bus.md_start, k == 5, k < 5);
      end
    end
    // accept in the IDLE cycle right after DONE
    drive(1'b1, 2'b00, 6'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.select !== 4'b0010 || bus.md_busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got v=%b sel=%b busy=%b exp v=1 sel=0010 busy=0",
               bus.out_valid, bus.select, bus.md_busy);
    end
    drive(1'b0, 2'b00, 6'b0);
    step();
  endtask

  task automatic test_divu_stall();
    int hilo_at;
    int bad_accept;
    int bad_busy;
    drive(1'b1, 2'b10, 6'b011011);
    step();
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 2'b11 || bus.md_busy !== 1'b1) begin
      errors++;
      $display("FAIL divu_start got st=%b op=%b busy=%b exp 1 11 1", bus.md_start, bus.md_op, bus.md_busy);
    end
    drive(1'b1, 2'b00, 6'b0);   // offered while busy, must be ignored
    hilo_at    = 0;
    bad_accept = 0;
    bad_busy   = 0;
    for (int k = 1; k <= 45 && hilo_at == 0; k++) begin
      bus.ex_stall = (k >= 10 && k <= 12);
      step();
      if (bus.hilo_we === 1'b1) begin
        hilo_at = k;
        drive(1'b0, 2'b00, 6'b0);
      end else begin
        if (bus.out_valid !== 1'b0) bad_accept++;
        if (bus.stall_req !== 1'b1 || bus.md_op !== 2'b11) bad_busy++;
      end
    end
    bus.ex_stall = 1'b0;
    checks++;
    if (hilo_at != 36) begin
      errors++;
      $display("FAIL divu_hilo_cycle got %0d exp 36", hilo_at);
    end
    checks++;
    if (bad_accept != 0) begin
      errors++;
      $display("FAIL divu_busy_accept got %0d accepted cycles exp 0", bad_accept);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL divu_busy_hold got %0d bad cycles exp 0", bad_busy);
    end
    drive(1'b0, 2'b00, 6'b0);
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    drive(1'b1, 2'b10, 6'b011010);
    step();
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 2'b01) begin
      errors++;
      $display("FAIL div_start got st=%b op=%b exp 1 01", bus.md_start, bus.md_op);
    end
    drive(1'b0, 2'b00, 6'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.hilo_we !== 1'b0 || bus.md_op !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid got busy=%b sr=%b we=%b op=%b exp 0 0 0 00",
               bus.md_busy, bus.stall_req, bus.hilo_we, bus.md_op);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.hilo_we === 1'b1 || bus.md_busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b01, 6'b0);
    step();
    drive(1'b1, 2'b10, 6'b111111);
    step();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.out_valid !== 1'b0 || bus.select !== 4'b0110 || bus.md_busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap got ill=%b v=%b sel=%b busy=%b exp 1 0 0110 0",
               bus.illegal_op, bus.out_valid, bus.select, bus.md_busy);
    end
    drive(1'b0, 2'b00, 6'b0);
    step();
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse got %b exp 0", bus.illegal_op);
    end
`else
    checks++;
    if (bus.illegal_op !== 1'b0 || bus.out_valid !== 1'b1 || bus.select !== 4'b0010) begin
      errors++;
      $display("FAIL illegal_default got ill=%b v=%b sel=%b exp 0 1 0010",
               bus.illegal_op, bus.out_valid, bus.select);
    end
    drive(1'b0, 2'b00, 6'b0);
    step();
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_stall = 1'b0;
    drive(1'b0, 2'b00, 6'b0);
    test_reset();
    test_rtype();
    test_aluop();
    test_mult_back_to_back();
    test_divu_stall();
    test_reset_mid();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
